step_ctrl: RTL and testbench

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 140 ++++++++++++++
 tb/tb_step_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// step_ctrl: run/single-step controller.
// Turns a divided-clock level into a TICK pulse, debounces the step button on
// TICKs, and sequences IDLE/RUN/STEP/HALT to issue one-cycle EN advance pulses
// that are counted in STEP_COUNT.
module step_ctrl #(
   parameter int DEB_TICKS = 3,
   parameter int CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CLK_2,
   input  logic             RUN_SW,
   input  logic             STEP_BTN,
   input  logic             HALT_REQ,
   input  logic             CLR_CNT,
   output logic             EN,
   output logic             TICK,
   output logic [1:0]       STATE,
   output logic [CNT_W-1:0] STEP_COUNT
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_HALT = 2'b11
   } state_t;

   // Debounce run length reaches this value on the last differing sample.
   localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS - 1);

   logic       c2_meta, c2_s;
   logic       run_meta, run_s;
   logic       btn_meta, btn_s;
   // Marks when c2_s holds a genuinely sampled CLK_2 value rather than the
   // reset-cleared zero, so a CLK_2 already high at release cannot arm.
   logic [1:0] sync_fill;
   logic       c2_prev;
   logic       armed;
   logic       deb_lvl;
   logic [3:0] deb_cnt;
   logic       press;
   state_t     state_q;

   // Two-flop synchronizers for the three asynchronous inputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         c2_meta   <= 1'b0;
         c2_s      <= 1'b0;
         run_meta  <= 1'b0;
         run_s     <= 1'b0;
         btn_meta  <= 1'b0;
         btn_s     <= 1'b0;
         sync_fill <= 2'b00;
      end else begin
         c2_meta   <= CLK_2;
         c2_s      <= c2_meta;
         run_meta  <= RUN_SW;
         run_s     <= run_meta;
         btn_meta  <= STEP_BTN;
         btn_s     <= btn_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   // Rising-edge detect on c2_s, gated until a real low level has been seen.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         c2_prev <= 1'b0;
         armed   <= 1'b0;
         TICK    <= 1'b0;
      end else begin
         c2_prev <= c2_s;
         armed   <= armed | (sync_fill[1] & ~c2_s);
         TICK    <= armed & c2_s & ~c2_prev;
      end
   end

   // Button debouncer sampled on TICK; press pulses when the level rises.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         deb_lvl <= 1'b0;
         deb_cnt <= 4'd0;
         press   <= 1'b0;
      end else begin
         press <= 1'b0;
         if (TICK) begin
            if (btn_s == deb_lvl) begin
               deb_cnt <= 4'd0;
            end else if (deb_cnt == DEB_LAST) begin
               deb_lvl <= btn_s;
               deb_cnt <= 4'd0;
               press   <= btn_s;
            end else begin
               deb_cnt <= deb_cnt + 4'd1;
            end
         end
      end
   end

   // Mode FSM with registered EN; HALT_REQ overrides every state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         EN      <= 1'b0;
      end else begin
         EN <= ((state_q == S_RUN) && TICK && run_s && !HALT_REQ) ||
               ((state_q == S_STEP) && !HALT_REQ);
         if (HALT_REQ) begin
            state_q <= S_HALT;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (run_s)      state_q <= S_RUN;
                  else if (press) state_q <= S_STEP;
                  else            state_q <= S_IDLE;
               end
               S_RUN:   state_q <= run_s ? S_RUN : S_IDLE;
               S_STEP:  state_q <= S_IDLE;
               // Leaving HALT needs the run switch off, forcing a re-arm.
               default: state_q <= run_s ? S_HALT : S_IDLE;
            endcase
         end
      end
   end

   // Advance counter; clear wins over a coincident increment.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         STEP_COUNT <= '0;
      end else if (CLR_CNT) begin
         STEP_COUNT <= '0;
      end else if (EN) begin
         STEP_COUNT <= STEP_COUNT + CNT_W'(1);
      end
   end

   assign STATE = state_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Testbench for step_ctrl: scenario tasks checked against a behavioural model.
module tb_step_ctrl;

   localparam int DEB = 3;
   localparam int CW  = 16;
   localparam int CWN = 4;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_STEP = 2'b10;
   localparam logic [1:0] S_HALT = 2'b11;

   // ---------------- clock / reset / signals ----------------
   logic CLK = 1'b0;
   logic RST_N, CLK_2, RUN_SW, STEP_BTN, HALT_REQ, CLR_CNT;
   logic EN, TICK;
   logic [1:0] STATE;
   logic [CW-1:0] STEP_COUNT;
   logic en_n, tick_n;
   logic [1:0] state_n;
   logic [CWN-1:0] cnt_n;

   always #5 CLK = ~CLK;

   step_ctrl #(.DEB_TICKS(DEB), .CNT_W(CW)) dut (
      .CLK(CLK), .RST_N(RST_N), .CLK_2(CLK_2), .RUN_SW(RUN_SW),
      .STEP_BTN(STEP_BTN), .HALT_REQ(HALT_REQ), .CLR_CNT(CLR_CNT),
      .EN(EN), .TICK(TICK), .STATE(STATE), .STEP_COUNT(STEP_COUNT)
   );

   // Narrow-counter instance sharing all inputs, so counter wrap is reachable.
   step_ctrl #(.DEB_TICKS(DEB), .CNT_W(CWN)) dut_n (
      .CLK(CLK), .RST_N(RST_N), .CLK_2(CLK_2), .RUN_SW(RUN_SW),
      .STEP_BTN(STEP_BTN), .HALT_REQ(HALT_REQ), .CLR_CNT(CLR_CNT),
      .EN(en_n), .TICK(tick_n), .STATE(state_n), .STEP_COUNT(cnt_n)
   );

   int n_checks = 0;
   int n_errors = 0;
   int edge_cnt = 0;
   logic c2_auto = 1'b0;
   int c2_ph = 0;
   int c2_half = 8;
   int rise_q[$];   // edge numbers at which a TICK is due

   // ---------------- behavioural model ----------------
   typedef struct packed { logic vld; logic v; } samp_t;
   samp_t c2_pipe[$];
   logic  run_pipe[$];
   logic  btn_pipe[$];
   logic  m_c2s, m_c2s_vld, m_c2s_prev, m_runs, m_btns;
   logic  m_armed, m_tick, m_en, m_deb, m_press;
   int    m_streak;
   logic [1:0] m_state;
   logic [CW-1:0] m_cnt;

   task automatic model_reset();
      c2_pipe.delete();  c2_pipe.push_back(samp_t'{vld: 1'b0, v: 1'b0});
      run_pipe.delete(); run_pipe.push_back(1'b0);
      btn_pipe.delete(); btn_pipe.push_back(1'b0);
      m_c2s = 0; m_c2s_vld = 0; m_c2s_prev = 0; m_runs = 0; m_btns = 0;
      m_armed = 0; m_tick = 0; m_en = 0; m_deb = 0; m_press = 0;
      m_streak = 0; m_state = S_IDLE; m_cnt = '0;
   endtask

   task automatic model_step(input logic c2, input logic run, input logic btn,
                             input logic halt, input logic clr);
      samp_t p;
      logic r, b, n_tick, n_armed, n_deb, n_press, n_en;
      int n_streak;
      logic [1:0] n_state;
      logic [CW-1:0] n_cnt;
      p = c2_pipe.pop_front();  c2_pipe.push_back(samp_t'{vld: 1'b1, v: c2});
      r = run_pipe.pop_front(); run_pipe.push_back(run);
      b = btn_pipe.pop_front(); btn_pipe.push_back(btn);
      n_tick  = m_armed && m_c2s && !m_c2s_prev;
      n_armed = m_armed || (m_c2s_vld && !m_c2s);
      n_deb = m_deb; n_streak = m_streak; n_press = 1'b0;
      if (m_tick) begin
         if (m_btns == m_deb) n_streak = 0;
         else if (m_streak + 1 >= DEB) begin
            n_deb = m_btns; n_streak = 0; n_press = m_btns;
         end else n_streak = m_streak + 1;
      end
      if (halt) n_state = S_HALT;
      else case (m_state)
         S_IDLE:  n_state = m_runs ? S_RUN : (m_press ? S_STEP : S_IDLE);
         S_RUN:   n_state = m_runs ? S_RUN : S_IDLE;
         S_STEP:  n_state = S_IDLE;
         default: n_state = m_runs ? S_HALT : S_IDLE;
      endcase
      n_en = (m_state == S_RUN && m_tick && m_runs && !halt) ||
             (m_state == S_STEP && !halt);
      n_cnt = clr ? '0 : (m_en ? m_cnt + 1'b1 : m_cnt);
      m_c2s_prev = m_c2s; m_c2s = p.v; m_c2s_vld = p.vld;
      m_runs = r; m_btns = b;
      m_tick = n_tick; m_armed = n_armed; m_deb = n_deb; m_streak = n_streak;
      m_press = n_press; m_state = n_state; m_en = n_en; m_cnt = n_cnt;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      logic c2v, rv, bv, hv, cv;
      c2v = CLK_2; rv = RUN_SW; bv = STEP_BTN; hv = HALT_REQ; cv = CLR_CNT;
      @(posedge CLK);
      if (RST_N) model_step(c2v, rv, bv, hv, cv);
      edge_cnt++;
      @(negedge CLK);
      if (c2_auto) begin
         c2_ph++;
         if (c2_ph >= c2_half) begin
            c2_ph = 0;
            CLK_2 = ~CLK_2;
            if (CLK_2) rise_q.push_back(edge_cnt + 3);
         end
      end
   endtask

   task automatic do_reset(input int hold);
      RST_N = 1'b0;
      model_reset();
      repeat (hold) cyc();
      RST_N = 1'b1;
   endtask

   task automatic quiet_inputs();
      RUN_SW = 0; STEP_BTN = 0; HALT_REQ = 0; CLR_CNT = 0;
      CLK_2 = 0; c2_auto = 0; c2_ph = 0; c2_half = 8;
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      RST_N = 1'b0;
      CLK_2 = 1'($urandom); RUN_SW = 1'($urandom); STEP_BTN = 1'($urandom);
      HALT_REQ = 1'($urandom); CLR_CNT = 1'($urandom);
      model_reset();
      #1;
      n_checks++;
      if ({EN, TICK, STATE, STEP_COUNT} !== {1'b0, 1'b0, S_IDLE, 16'h0}) begin
         n_errors++;
         $display("FAIL reset_async got=%h exp=%h", {EN, TICK, STATE, STEP_COUNT},
                  {1'b0, 1'b0, S_IDLE, 16'h0});
      end
      for (int i = 0; i < 4; i++) begin
         CLK_2 = 1'($urandom); RUN_SW = 1'($urandom); HALT_REQ = 1'($urandom);
         cyc();
         n_checks++;
         if ({EN, TICK, STATE, STEP_COUNT} !== {m_en, m_tick, m_state, m_cnt}) begin
            n_errors++;
            $display("FAIL reset_hold got=%h exp=%h", {EN, TICK, STATE, STEP_COUNT},
                     {m_en, m_tick, m_state, m_cnt});
         end
      end
      quiet_inputs();
      RST_N = 1'b1;
      repeat (4) cyc();
   endtask

   task automatic test_run();
      logic exp_t, prev_t, last_en;
      quiet_inputs();
      do_reset(2);
      RUN_SW = 1; c2_auto = 1; rise_q.delete();
      repeat (4) cyc();
      n_checks++;
      if (STATE !== S_RUN) begin
         n_errors++;
         $display("FAIL run_state_by4 got=%b exp=%b", STATE, S_RUN);
      end
      prev_t = 0; last_en = EN;
      for (int i = 0; i < 66; i++) begin
         cyc();
         exp_t = (rise_q.size() > 0 && rise_q[0] == edge_cnt);
         if (exp_t) rise_q.delete(0);
         n_checks++;
         if (TICK !== exp_t) begin
            n_errors++;
            $display("FAIL run_tick_latency e=%0d got=%b exp=%b", edge_cnt, TICK, exp_t);
         end
         n_checks++;
         if (EN !== prev_t) begin
            n_errors++;
            $display("FAIL run_en_after_tick e=%0d got=%b exp=%b", edge_cnt, EN, prev_t);
         end
         n_checks++;
         if ({EN, TICK, STATE, STEP_COUNT} !== {m_en, m_tick, m_state, m_cnt}) begin
            n_errors++;
            $display("FAIL run_model e=%0d got=%h exp=%h", edge_cnt,
                     {EN, TICK, STATE, STEP_COUNT}, {m_en, m_tick, m_state, m_cnt});
         end
         n_checks++;
         if (EN && last_en) begin
            n_errors++;
            $display("FAIL run_en_back_to_back e=%0d got=11 exp=not 11", edge_cnt);
         end
         last_en = EN;
         prev_t = exp_t;
      end
      n_checks++;
      if (STEP_COUNT !== 16'd4) begin
         n_errors++;
         $display("FAIL run_count4 got=%0d exp=4", STEP_COUNT);
      end
   endtask

   task automatic test_step();
      int steps, en_hold, en_rel;
      quiet_inputs();
      do_reset(2);
      c2_auto = 1;
      steps = 0; en_hold = 0; en_rel = 0;
      STEP_BTN = 1; repeat ($urandom_range(1, 4)) cyc();
      STEP_BTN = 0; repeat ($urandom_range(1, 4)) cyc();
      STEP_BTN = 1;
      for (int i = 0; i < 160; i++) begin
         if (i == 80) STEP_BTN = 0;
         cyc();
         if (STATE === S_STEP) steps++;
         if (EN === 1'b1) begin
            if (i < 80) en_hold++; else en_rel++;
         end
         n_checks++;
         if ({EN, TICK, STATE, STEP_COUNT} !== {m_en, m_tick, m_state, m_cnt}) begin
            n_errors++;
            $display("FAIL step_model e=%0d got=%h exp=%h", edge_cnt,
                     {EN, TICK, STATE, STEP_COUNT}, {m_en, m_tick, m_state, m_cnt});
         end
      end
      n_checks++;
      if (steps != 1) begin
         n_errors++; $display("FAIL step_cycles got=%0d exp=1", steps);
      end
      n_checks++;
      if (en_hold != 1) begin
         n_errors++; $display("FAIL step_en_hold got=%0d exp=1", en_hold);
      end
      n_checks++;
      if (en_rel != 0) begin
         n_errors++; $display("FAIL step_en_release got=%0d exp=0", en_rel);
      end
      n_checks++;
      if (STEP_COUNT !== 16'd1) begin
         n_errors++; $display("FAIL step_count got=%0d exp=1", STEP_COUNT);
      end
   endtask

   task automatic test_halt();
      int guard;
      quiet_inputs();
      do_reset(2);
      RUN_SW = 1; c2_auto = 1;
      guard = 0;
      while (!(m_tick && m_state == S_RUN) && guard < 60) begin
         cyc(); guard++;
      end
      n_checks++;
      if (!(m_tick && m_state == S_RUN)) begin
         n_errors++; $display("FAIL halt_wait_tick got=timeout exp=tick in RUN");
      end
      HALT_REQ = 1;
      cyc();
      n_checks++;
      if ({EN, STATE} !== {1'b0, S_HALT}) begin
         n_errors++; $display("FAIL halt_on_tick got=%b exp=%b", {EN, STATE}, {1'b0, S_HALT});
      end
      cyc();
      n_checks++;
      if (EN !== 1'b0) begin
         n_errors++; $display("FAIL halt_no_en got=%b exp=0", EN);
      end
      HALT_REQ = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n_checks++;
         if ({EN, STATE} !== {1'b0, S_HALT}) begin
            n_errors++;
            $display("FAIL halt_stay_run_on got=%b exp=%b", {EN, STATE}, {1'b0, S_HALT});
         end
      end
      RUN_SW = 0;
      repeat (3) cyc();
      n_checks++;
      if (STATE !== S_IDLE) begin
         n_errors++; $display("FAIL halt_exit got=%b exp=%b", STATE, S_IDLE);
      end
   endtask

   task automatic test_wrap_clear();
      int guard;
      quiet_inputs();
      do_reset(2);
      RUN_SW = 1; c2_auto = 1; c2_half = 1;
      guard = 0;
      while (!(m_en && m_cnt == 15) && guard < 200) begin
         cyc(); guard++;
      end
      cyc();
      n_checks++;
      if ({cnt_n, STEP_COUNT} !== {4'h0, 16'd16}) begin
         n_errors++;
         $display("FAIL wrap_count got=%h exp=%h", {cnt_n, STEP_COUNT}, {4'h0, 16'd16});
      end
      CLR_CNT = 1; cyc(); CLR_CNT = 0;
      n_checks++;
      if (STEP_COUNT !== 16'd0) begin
         n_errors++; $display("FAIL clear_plain got=%0d exp=0", STEP_COUNT);
      end
      guard = 0;
      while (!(m_en && m_cnt == 5) && guard < 200) begin
         cyc(); guard++;
      end
      n_checks++;
      if (!(m_en && m_cnt == 5)) begin
         n_errors++; $display("FAIL clear_wait got=timeout exp=EN at count 5");
      end
      CLR_CNT = 1; cyc(); CLR_CNT = 0;
      n_checks++;
      if ({cnt_n, STEP_COUNT} !== {4'h0, 16'd0}) begin
         n_errors++;
         $display("FAIL clear_vs_en got=%h exp=%h", {cnt_n, STEP_COUNT}, {4'h0, 16'd0});
      end
   endtask

   task automatic test_reset_mid();
      int ticks, guard;
      quiet_inputs();
      CLK_2 = 1; RUN_SW = 1;
      do_reset(2);
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (TICK === 1'b1 || EN === 1'b1) ticks++;
      end
      n_checks++;
      if (ticks != 0) begin
         n_errors++; $display("FAIL high_at_release got=%0d exp=0 tick/en cycles", ticks);
      end
      CLK_2 = 0; repeat (4) cyc();
      CLK_2 = 1; repeat (3) cyc();
      n_checks++;
      if (TICK !== 1'b1) begin
         n_errors++; $display("FAIL fresh_tick got=%b exp=1", TICK);
      end
      cyc();
      n_checks++;
      if (EN !== 1'b1) begin
         n_errors++; $display("FAIL fresh_en got=%b exp=1", EN);
      end
      c2_auto = 1; c2_ph = 0;
      guard = 0;
      while (!m_en && guard < 60) begin
         cyc(); guard++;
      end
      #2;
      RST_N = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({EN, TICK, STATE, STEP_COUNT} !== {1'b0, 1'b0, S_IDLE, 16'h0}) begin
         n_errors++;
         $display("FAIL reset_mid_pulse got=%h exp=%h", {EN, TICK, STATE, STEP_COUNT},
                  {1'b0, 1'b0, S_IDLE, 16'h0});
      end
      cyc();
      RST_N = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         n_checks++;
         if ({EN, TICK, STATE, STEP_COUNT} !== {m_en, m_tick, m_state, m_cnt}) begin
            n_errors++;
            $display("FAIL after_reset_model e=%0d got=%h exp=%h", edge_cnt,
                     {EN, TICK, STATE, STEP_COUNT}, {m_en, m_tick, m_state, m_cnt});
         end
      end
   endtask

   task automatic test_random();
      logic last_en;
      quiet_inputs();
      do_reset(2);
      c2_auto = 1; c2_half = $urandom_range(1, 5);
      last_en = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) RUN_SW = ~RUN_SW;
         if ($urandom_range(0, 19) == 0) STEP_BTN = ~STEP_BTN;
         if ($urandom_range(0, 29) == 0) HALT_REQ = ~HALT_REQ;
         CLR_CNT = ($urandom_range(0, 49) == 0);
         cyc();
         n_checks++;
         if ({EN, TICK, STATE, STEP_COUNT} !== {m_en, m_tick, m_state, m_cnt}) begin
            n_errors++;
            $display("FAIL rand_model e=%0d got=%h exp=%h", edge_cnt,
                     {EN, TICK, STATE, STEP_COUNT}, {m_en, m_tick, m_state, m_cnt});
         end
         n_checks++;
         if ({en_n, tick_n, state_n, cnt_n} !== {m_en, m_tick, m_state, m_cnt[CWN-1:0]}) begin
            n_errors++;
            $display("FAIL rand_narrow e=%0d got=%h exp=%h", edge_cnt,
                     {en_n, tick_n, state_n, cnt_n}, {m_en, m_tick, m_state, m_cnt[CWN-1:0]});
         end
         n_checks++;
         if (EN && last_en) begin
            n_errors++; $display("FAIL rand_en_back_to_back e=%0d got=11 exp=not 11", edge_cnt);
         end
         last_en = EN;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      quiet_inputs();
      test_reset();
      test_run();
      test_step();
      test_halt();
      test_wrap_clear();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
